// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the RV32M multiply/divide unit:
//   - M-extension alu_ctl op-code constants
//   - op-class helper functions (is_mul, is_div, is_signed_div, is_rem)
//   - FSM state encoding for muldiv_unit
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [4:0] OP_MUL   = 5'b00010;
    localparam logic [4:0] OP_MULH  = 5'b00011;
    localparam logic [4:0] OP_MULSU = 5'b00100;
    localparam logic [4:0] OP_MULU  = 5'b00101;
    localparam logic [4:0] OP_DIV   = 5'b00110;
    localparam logic [4:0] OP_DIVU  = 5'b00111;
    localparam logic [4:0] OP_REM   = 5'b01000;
    localparam logic [4:0] OP_REMU  = 5'b01001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Multiply-class codes occupy a contiguous range.
    function automatic logic is_mul(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_MULU);
    endfunction

    // Divide/remainder-class codes occupy a contiguous range.
    function automatic logic is_div(input logic [4:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

    // Divide ops that treat operands as two's complement.
    function automatic logic is_signed_div(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Divide ops that return the remainder rather than the quotient.
    function automatic logic is_rem(input logic [4:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// -----------------------------------------------------------------------------
// div_core
// Iterative restoring radix-2 divider on unsigned magnitudes, one quotient bit
// per step, MSB first. The caller loads magnitudes, pulses step XLEN times and
// reads quotient/remainder; last flags the step that completes the divide.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   load                 capture dividend/divisor, clear remainder and counter
//   step                 perform one restoring iteration
//   dividend, divisor    unsigned operands (sampled on load)
//   quotient, remainder  current quotient / partial remainder
//   last                 high while the counter sits on the final iteration
// -----------------------------------------------------------------------------
module div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] quot_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] dvs_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN:0]   acc_s;
    logic [XLEN:0]   diff_s;

    // Trial subtraction: shift next dividend bit into the XLEN+1 accumulator.
    // The partial remainder is always below the divisor, so a set top bit of
    // the difference means the subtraction went negative.
    always_comb begin
        acc_s  = {rem_r, quot_r[XLEN-1]};
        diff_s = acc_s - {1'b0, dvs_r};
    end

    // Divider state: load initialises, step performs one iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_r <= {XLEN{1'b0}};
            rem_r  <= {XLEN{1'b0}};
            dvs_r  <= {XLEN{1'b0}};
            cnt_r  <= {CW{1'b0}};
        end else if (load) begin
            quot_r <= dividend;
            rem_r  <= {XLEN{1'b0}};
            dvs_r  <= divisor;
            cnt_r  <= {CW{1'b0}};
        end else if (step) begin
            cnt_r <= cnt_r + CW'(1);
            if (diff_s[XLEN]) begin
                rem_r  <= acc_s[XLEN-1:0];
                quot_r <= {quot_r[XLEN-2:0], 1'b0};
            end else begin
                rem_r  <= diff_s[XLEN-1:0];
                quot_r <= {quot_r[XLEN-2:0], 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign quotient  = quot_r;
    assign remainder = rem_r;
    assign last      = (cnt_r == CW'(XLEN - 1));

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle RV32M execution unit. Accepts one M-extension op at a time and
// returns a single result with a busy/done handshake.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start          request; taken only in IDLE with an M alu_ctl code
//   alu_ctl        op code, sampled on accepted start
//   op_a, op_b     rs1 / rs2, sampled on accepted start
//   flush          abort any in-flight op; back to IDLE next cycle
//   busy           op in flight (MUL/DIV/FIX), pipeline must hold
//   done           one-cycle pulse, result valid
//   result         last completed result, held until the next one
// Latency from accepted start in cycle N: mul and div special cases done at
// N+2, iterative divide done at N+XLEN+2.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      alu_ctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] ZERO_W = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_W = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_W  = {1'b1, {(XLEN-1){1'b0}}};

    // Two's complement negate, wrapping.
    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_e            state_r;
    logic              busy_r;
    logic              done_r;
    logic [XLEN-1:0]   result_r;
    logic [4:0]        op_r;
    logic [XLEN-1:0]   a_r;
    logic [XLEN-1:0]   b_r;
    logic              special_r;
    logic              zero_r;
    logic              neg_q_r;
    logic              neg_r_r;

    logic              accept_s;
    logic              sdiv_s;
    logic              zero_s;
    logic              special_s;
    logic [XLEN-1:0]   dividend_s;
    logic [XLEN-1:0]   divisor_s;
    logic              div_load_s;
    logic              div_step_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic              div_last_s;
    logic [2*XLEN-1:0] a_ext_s;
    logic [2*XLEN-1:0] b_ext_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   mul_res_s;
    logic [XLEN-1:0]   quot_fix_s;
    logic [XLEN-1:0]   rem_fix_s;
    logic [XLEN-1:0]   fix_res_s;

    // Start decode: acceptance, special-case detection and divider magnitudes.
    // Flush in the same cycle suppresses acceptance.
    always_comb begin
        accept_s   = start && (state_r == ST_IDLE) && !flush &&
                     (is_mul(alu_ctl) || is_div(alu_ctl));
        sdiv_s     = is_signed_div(alu_ctl);
        zero_s     = (op_b == ZERO_W);
        special_s  = is_div(alu_ctl) &&
                     (zero_s || (sdiv_s && (op_a == MIN_W) && (op_b == ONES_W)));
        dividend_s = (sdiv_s && op_a[XLEN-1]) ? neg_w(op_a) : op_a;
        divisor_s  = (sdiv_s && op_b[XLEN-1]) ? neg_w(op_b) : op_b;
        div_load_s = accept_s && is_div(alu_ctl) && !special_s;
        div_step_s = (state_r == ST_DIV) && !flush;
    end

    div_core #(.XLEN(XLEN)) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load_s),
        .step      (div_step_s),
        .dividend  (dividend_s),
        .divisor   (divisor_s),
        .quotient  (quot_s),
        .remainder (rem_s),
        .last      (div_last_s)
    );

    // Full-width product of the captured operands; each op picks per-operand
    // sign extension, then mul takes the low half and the rest the high half.
    always_comb begin
        a_ext_s   = {{XLEN{a_r[XLEN-1] && (op_r != OP_MULU)}}, a_r};
        b_ext_s   = {{XLEN{b_r[XLEN-1] && ((op_r == OP_MUL) || (op_r == OP_MULH))}}, b_r};
        prod_s    = a_ext_s * b_ext_s;
        mul_res_s = (op_r == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    // Sign fix-up of the magnitude divide, or the fixed special-case answers.
    always_comb begin
        quot_fix_s = neg_q_r ? neg_w(quot_s) : quot_s;
        rem_fix_s  = neg_r_r ? neg_w(rem_s) : rem_s;
        if (special_r) begin
            if (zero_r) begin
                fix_res_s = is_rem(op_r) ? a_r : ONES_W;
            end else begin
                fix_res_s = is_rem(op_r) ? ZERO_W : MIN_W;
            end
        end else begin
            fix_res_s = is_rem(op_r) ? rem_fix_s : quot_fix_s;
        end
    end

    // Control FSM with registered busy/done/result and operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= {XLEN{1'b0}};
            op_r      <= 5'b00000;
            a_r       <= {XLEN{1'b0}};
            b_r       <= {XLEN{1'b0}};
            special_r <= 1'b0;
            zero_r    <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
        end else if (flush) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        op_r      <= alu_ctl;
                        a_r       <= op_a;
                        b_r       <= op_b;
                        special_r <= special_s;
                        zero_r    <= zero_s;
                        neg_q_r   <= sdiv_s && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                        neg_r_r   <= sdiv_s && op_a[XLEN-1];
                        busy_r    <= 1'b1;
                        if (is_mul(alu_ctl)) begin
                            state_r <= ST_MUL;
                        end else if (special_s) begin
                            state_r <= ST_FIX;
                        end else begin
                            state_r <= ST_DIV;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    result_r <= mul_res_s;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DIV: begin
                    if (div_last_s) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= ST_DIV;
                    end
                end
                ST_FIX: begin
                    result_r <= fix_res_s;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed vectors with hand-computed results and latencies for muldiv_unit.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  alu_ctl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          vec_cnt;
    int          miss_cnt;
    logic [31:0] last_res;

    muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .alu_ctl (alu_ctl),
        .op_a    (op_a),
        .op_b    (op_b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every vector, reports miscompares.
    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op from a negedge; measure done latency (cycles after the
    // accepting edge), busy in N+1, result at done, and single-cycle done.
    // With poke set, a competing mul start is driven while busy.
    task automatic do_op(input string tag, input logic [4:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input bit poke);
        int cyc;
        bit seen;
        logic busy1;
        alu_ctl = ctl; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; seen = 1'b0; busy1 = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) busy1 = busy;
            if (done) begin
                seen = 1'b1;
                start = 1'b0;
            end else begin
                start = poke && (cyc == 5);
                if (poke && cyc == 5) begin
                    alu_ctl = OP_MUL; op_a = 32'd3; op_b = 32'd3;
                end
            end
        end
        check_vec({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check_vec({tag, "_busy"}, {31'd0, busy1}, 32'd1);
        check_vec({tag, "_res"}, result, exp_res);
        @(negedge clk);
        check_vec({tag, "_pulse"}, {31'd0, done}, 32'd0);
        last_res = exp_res;
    endtask

    // Watch n cycles; busy or done must stay low throughout.
    task automatic quiet(input string tag, input int n);
        int hits;
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy || done) hits++;
        end
        check_vec(tag, 32'(hits), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_cnt = 0; miss_cnt = 0; last_res = 32'd0;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        alu_ctl = 5'b00000; op_a = 32'd0; op_b = 32'd0;
        repeat (2) @(negedge clk);
        check_vec("rst_busy", {31'd0, busy}, 32'd0);
        check_vec("rst_done", {31'd0, done}, 32'd0);
        check_vec("rst_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiply family.
        do_op("mul",   OP_MUL,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2, 1'b0);
        do_op("mulh",  OP_MULH,  32'h80000000, 32'h80000000, 32'h40000000, 2, 1'b0);
        do_op("mulu",  OP_MULU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 1'b0);
        do_op("mulsu", OP_MULSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 2, 1'b0);
        do_op("mul_lo",OP_MUL,   32'h00010000, 32'h00010000, 32'h00000000, 2, 1'b0);

        // Iterative divide.
        do_op("div",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0);
        do_op("rem",   OP_REM,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
        do_op("remu",  OP_REMU,  32'd100,      32'd7,        32'd2,        34, 1'b0);
        do_op("div_nn",OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        34, 1'b0);
        do_op("divu_m",OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34, 1'b0);

        // Special cases.
        do_op("divu_z",OP_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 2, 1'b0);
        do_op("rem_z", OP_REM,   32'd5,        32'd0,        32'd5,        2, 1'b0);
        do_op("div_ov",OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 1'b0);
        do_op("rem_ov",OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'd0,        2, 1'b0);

        // Start while busy is ignored: divu 100/7 still yields 14 at N+34.
        do_op("poke",  OP_DIVU,  32'd100,      32'd7,        32'd14,       34, 1'b1);

        // Flush at N+10 of a divide.
        alu_ctl = OP_DIV; op_a = 32'hFFFFFFF9; op_b = 32'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_vec("flush_busy", {31'd0, busy}, 32'd0);
        check_vec("flush_done", {31'd0, done}, 32'd0);
        check_vec("flush_result", result, last_res);
        do_op("flush_new", OP_MUL, 32'd6, 32'd7, 32'd42, 2, 1'b0);
        quiet("flush_quiet", 40);

        // Flush and start together in IDLE: start dropped.
        alu_ctl = OP_MUL; op_a = 32'd9; op_b = 32'd9; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        quiet("flush_start", 5);
        check_vec("flush_start_res", result, last_res);

        // Non-M code is ignored.
        alu_ctl = 5'b00000; op_a = 32'd1; op_b = 32'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        quiet("non_m", 5);
        check_vec("non_m_res", result, last_res);

        // Asynchronous reset between edges mid-divide.
        alu_ctl = OP_DIVU; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_vec("arst_busy", {31'd0, busy}, 32'd0);
        check_vec("arst_done", {31'd0, done}, 32'd0);
        check_vec("arst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet("arst_quiet", 40);

        // Unit is usable again after reset.
        do_op("post_rst", OP_DIVU, 32'd1000, 32'd3, 32'd333, 34, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
